// File: rtl/csa4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : csa4_pkg                                                       |
// | Brief   : Shared types and constants for the bit-serial 4-operand adder. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package csa4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Inter-column carry never exceeds 4, so three bits hold it.
    localparam int KCW = 3;

    function automatic int res_width(input int w);
        return w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/col_reduce4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : col_reduce4                                                    |
// | Brief   : One column of the 4:2 reduction: four bits plus carry state in,|
// |           sum bit and next carry state out. Purely combinational.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module col_reduce4
    import csa4_pkg::*;
(
    input  logic [3:0]     bits,
    input  logic [KCW-1:0] kc,
    output logic           sum,
    output logic [KCW-1:0] kc_next
);

    // Column total reaches 8 when all bits are set and kc is 4.
    logic [KCW:0] w_t;

    always_comb begin
        w_t = {{KCW{1'b0}}, bits[0]} + {{KCW{1'b0}}, bits[1]}
            + {{KCW{1'b0}}, bits[2]} + {{KCW{1'b0}}, bits[3]}
            + {1'b0, kc};
        sum     = w_t[0];
        kc_next = w_t[KCW:1];
    end

endmodule
`default_nettype wire

// File: rtl/csa4_serial_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : csa4_serial_sched                                              |
// | Brief   : Bit-serial a+b+c+d over one shared column slice, W data columns|
// |           plus two carry-flush columns, valid/ready on both sides.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csa4_serial_sched
    import csa4_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 3)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    input  logic [W-1:0]        c,
    input  logic [W-1:0]        d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W+1:0]        result,
    output logic                busy
);

    localparam int             RW           = res_width(W);
    localparam logic [CW-1:0]  c_last_run   = CW'(W - 1);
    localparam logic [CW-1:0]  c_last_flush = CW'(W + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_c;
    logic [W-1:0]    r_d;
    logic [KCW-1:0]  r_kc;
    logic [KCW-1:0]  w_kc_nxt;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_res;
    logic            w_accept;
    logic [3:0]      w_col;
    logic            w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_last_run) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (r_cnt == c_last_flush) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flush columns feed zeros so only the pending carry drains out.
    assign w_col = (r_state == ST_RUN) ? {r_d[0], r_c[0], r_b[0], r_a[0]} : 4'b0000;

    col_reduce4 u_col (
        .bits    (w_col),
        .kc      (r_kc),
        .sum     (w_sum),
        .kc_next (w_kc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_kc  <= '0;
            r_cnt <= '0;
            r_res <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= c;
            r_d   <= d;
            r_kc  <= '0;
            r_cnt <= '0;
        end else if (busy) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= r_c >> 1;
            r_d   <= r_d >> 1;
            r_kc  <= w_kc_nxt;
            r_cnt <= r_cnt + CW'(1);
            // After W+2 shifts the first column's sum bit lands in bit 0.
            r_res <= {w_sum, r_res[RW-1:1]};
        end
    end

    assign result = r_res;

endmodule
`default_nettype wire

// File: tb/tb_csa4_serial_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_csa4_serial_sched                                           |
// | Brief   : Self-checking bench: cycle model for W=8, sweep for W=4,       |
// |           exhaustive column-slice table.                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_csa4_serial_sched;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, out_ready, in_ready, out_valid, busy;
    logic [7:0]   a, b, c, d;
    logic [9:0]   result;

    logic         rst4_n, iv4, or4, ir4, ov4, busy4;
    logic [3:0]   a4, b4, c4, d4;
    logic [5:0]   res4;

    logic [3:0]   cr_bits;
    logic [2:0]   cr_kc, cr_kn;
    logic         cr_sum;

    csa4_serial_sched #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    csa4_serial_sched #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .c(c4), .d(d4), .out_valid(ov4), .out_ready(or4),
        .result(res4), .busy(busy4)
    );

    col_reduce4 u_cr (.bits(cr_bits), .kc(cr_kc), .sum(cr_sum), .kc_next(cr_kn));

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: accept -> W+2 busy cycles -> done until out_ready.
    int         m_phase;
    int         m_left;
    logic [9:0] m_exp, m_last;
    int         acc_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_left  = 0;
            m_last  = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   = 10'(int'(a) + int'(b) + int'(c) + int'(d));
                    m_left  = W + 2;
                    m_phase = 1;
                    acc_q.push_back(cyc);
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_last  = m_exp;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("in_ready", in_ready, m_phase == 0);
            check("out_valid", out_valid, m_phase == 2);
            check("busy", busy, m_phase == 1);
            if (m_phase != 1) check("result", result, m_last);
        end
    end

    int kc4_max = 0;
    always @(posedge clk) if (int'(dut4.r_kc) > kc4_max) kc4_max = int'(dut4.r_kc);

    task automatic op8(input logic [7:0] ia, ib, ic, id, input logic [9:0] exp);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        @(negedge clk);
        a = ia; b = ib; c = ic; d = id; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bc++;
        end
        check("latency", lat - 1, W + 2);
        check("busy_cycles", bc, W + 2);
        check("sum8", result, exp);
        check("kc_at_done", dut.r_kc, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        int first;
        logic [15:0] v;

        rst_n = 1'b0; rst4_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; c4 = '0; d4 = '0;
        cr_bits = '0; cr_kc = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_kc", dut.r_kc, 0);
        check("rst_cnt", dut.r_cnt, 0);
        rst_n = 1'b1; rst4_n = 1'b1;
        chk_en = 1'b1;

        // Column slice on its own, all legal carry states.
        for (int k = 0; k <= 4; k++) begin
            for (int bb = 0; bb < 16; bb++) begin
                cr_bits = 4'(bb);
                cr_kc   = 3'(k);
                #1;
                t = $countones(cr_bits) + k;
                check("cr_sum", cr_sum, t % 2);
                check("cr_kc_next", cr_kn, t / 2);
                check("cr_kc_bound", cr_kn <= 3'd4, 1);
            end
        end
        cr_bits = 4'hF; cr_kc = 3'd4; #1;
        check("cr_pin_sum", cr_sum, 0);
        check("cr_pin_kc", cr_kn, 4);

        op8(8'hFF, 8'hFF, 8'hFF, 8'hFF, 10'h3FC);
        check("model_pin_3fc", m_last, 10'h3FC);
        op8(8'd1, 8'd2, 8'd3, 8'd4, 10'h00A);
        check("model_pin_00a", m_last, 10'h00A);
        op8(8'd0, 8'd0, 8'd0, 8'd0, 10'h000);

        // Backpressure: DONE held with stable result.
        @(negedge clk) out_ready = 1'b0;
        op8(8'h80, 8'h80, 8'h80, 8'h80, 10'h200);
        repeat (5) begin
            @(negedge clk);
            check("bp_result", result, 10'h200);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // in_valid held high with operands changing every cycle.
        first = acc_q.size();
        @(negedge clk) in_valid = 1'b1;
        repeat (40) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drained", in_ready, 1);
        check("b2b_accepts", acc_q.size() - first >= 3, 1);
        for (int i = first + 1; i < acc_q.size(); i++) begin
            check("b2b_interval", acc_q[i] - acc_q[i-1], W + 4);
        end

        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb, rc, rd;
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            op8(ra, rb, rc, rd, 10'(int'(ra) + int'(rb) + int'(rc) + int'(rd)));
        end

        // Asynchronous reset while columns are still being processed.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; c = 8'hFF; d = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 0);
        check("arst_kc", dut.r_kc, 0);
        @(negedge clk) rst_n = 1'b1;
        op8(8'h12, 8'h34, 8'h56, 8'h78, 10'h114);

        // W=4 sweep: corners then random operand sets.
        for (int i = 0; i < 1500; i++) begin
            v = (i == 0) ? 16'h0000 : (i == 1) ? 16'hFFFF : 16'($urandom);
            @(negedge clk);
            a4 = v[3:0]; b4 = v[7:4]; c4 = v[11:8]; d4 = v[15:12]; iv4 = 1'b1;
            @(posedge clk);
            #1 iv4 = 1'b0;
            n = 0;
            while (!ov4 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("sum4", res4, int'(v[3:0]) + int'(v[7:4]) + int'(v[11:8]) + int'(v[15:12]));
        end
        check("kc4_bound", kc4_max <= 4, 1);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
